mem_initiator: RTL and testbench
================================

// Module: mem_initiator
// PURPOSE
//  Master side of the on-chip SRAM port (read/write/addr/data/byte_select/mem_ready).
//  Accepts one load/store at a time from the core (valid/ready), converts byte/half/word
//  accesses to word address + byte mask + lane-aligned data, waits on mem_ready_i,
//  and returns aligned, sign/zero-extended load data. Sits between core LSU and the SRAM wrapper.
// PARAMETERS
//  ADDR_W      15   word-address width on memory side (byte address space = 2^(ADDR_W+2))
//  TIMEOUT     64   max wait cycles for mem_ready_i in a transfer before error response
// PORTS
//  clk_i             in   1      clock; all logic on rising edge
//  rst_i             in   1      synchronous, active-high reset
//  req_valid_i       in   1      core request valid
//  req_ready_o       out  1      request accepted on cycle valid&ready
//  req_we_i          in   1      1=store, 0=load
//  req_addr_i        in   32     byte address
//  req_size_i        in   2      00=byte 01=half 10=word (11 -> error)
//  req_unsigned_i    in   1      load: 1=zero-extend, 0=sign-extend
//  req_wdata_i       in   32     store data, right-justified
//  rsp_valid_o       out  1      one-cycle response pulse (no backpressure)
//  rsp_rdata_o       out  32     load data, extended; 0 for stores/errors
//  rsp_err_o         out  1      misaligned, out-of-range, bad size or timeout
//  mem_read_o        out  1      to SRAM read_i
//  mem_write_o       out  1      to SRAM write_i
//  mem_addr_o        out  ADDR_W word address = req_addr_i[ADDR_W+1:2]
//  mem_data_o        out  32     lane-replicated write data
//  mem_byte_select_o out  4      byte mask
//  mem_ready_i       in   1      SRAM ready; transfer completes at edge with strobe&ready
//  mem_data_i        in   32     SRAM read data, valid when mem_read_o&mem_ready_i
// BEHAVIOUR
//  Reset: state IDLE; req_ready_o=0 while rst_i high; all other outputs 0; counter 0.
//  States: IDLE, READ, WRITE, RESP.
//   IDLE : req_ready_o=1. On valid: latch request. Error check first:
//          size=11, half with addr[0]!=0, word with addr[1:0]!=0, addr[31:ADDR_W+2]!=0
//          -> RESP with err=1, no memory strobe. Else we ? WRITE : READ.
//   WRITE: mem_write_o=1, addr/data/mask stable; mem_ready_i=1 -> RESP.
//   READ : mem_read_o=1, addr/mask stable; mem_ready_i=1 -> capture+extend data -> RESP.
//   RESP : rsp_valid_o=1 one cycle, req_ready_o=0, strobes 0 -> IDLE.
//  Strobes are 0 in RESP/IDLE, so every read starts with a rising mem_read_o edge
//   (SRAM holds mem_ready_i low that first cycle).
//  Latency (accept edge = 0, ready as SRAM gives): store rsp_valid in cycle 2;
//   load rsp_valid in cycle 3; error rsp_valid in cycle 1. Throughput 1 req per 3/4 cycles.
//  Byte mask: B -> 4'b0001<<addr[1:0]; H -> 4'b0011<<addr[1:0]; W -> 4'b1111.
//  Write data: B {4{wdata[7:0]}}, H {2{wdata[15:0]}}, W wdata.
//  Read data: B lane addr[1:0], H lane addr[1], extended per req_unsigned_i.
//  Timeout: counter clears on entering READ/WRITE, increments each cycle without ready;
//   at TIMEOUT-1 without ready -> RESP err=1, strobes drop. Ready in the same cycle wins.
//  Reset mid-transfer: next edge IDLE, strobes 0, pending request dropped, no response.
//  req_valid_i outside IDLE is ignored (not accepted).
// STRUCTURE
//  mem_pkg: SIZE_B/SIZE_H/SIZE_W/SIZE_BAD encodings, state encoding constants.
//  Sub-module mem_lane_align (combinational): size+offset+wdata -> mask, mem_data;
//   size+offset+unsigned+mem_data_i -> extended rdata. FSM, latches, timeout in top.
// TESTING (SRAM model = wrapper behaviour: ready low on read rise/addr change)
//  Reset 3 cycles with req_valid_i=1 -> no strobe, req_ready_o=0, no rsp_valid_o.
//  Store W addr 0x10 data 0xDEADBEEF -> mem_addr_o=4, mask 1111, rsp cycle 2, err=0.
//  Store B 0x13 data 0xA5, then load B signed 0x13 -> mask 1000, rdata 0xFFFFFFA5;
//   unsigned -> 0x000000A5; load cycle 3.
//  Load H addr 0x21 -> no strobe, rsp cycle 1 err=1; size=11 also err=1.
//  Model holds mem_ready_i=0 forever -> err=1 after TIMEOUT cycles; next req completes ok.
//  rst_i pulsed during READ -> strobes 0 next cycle, no rsp; new load after reset correct.

Source files
------------

// File: rtl/mem_initiator_pkg.sv
// Shared encodings for the SRAM initiator: access sizes, FSM states and the request legality check.
package mem_initiator_pkg;

    typedef enum logic [1:0] {
        SIZE_B   = 2'b00,
        SIZE_H   = 2'b01,
        SIZE_W   = 2'b10,
        SIZE_BAD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // A request is rejected for an illegal size, natural misalignment, or address bits above the SRAM.
    function automatic logic req_bad(input logic [1:0] size, input logic [31:0] addr,
                                     input int unsigned addr_w);
        logic [31:0] hi;
        hi      = addr >> (addr_w + 2);
        req_bad = (hi != '0);
        case (size)
            SIZE_H:   if (addr[0]) req_bad = 1'b1;
            SIZE_W:   if (addr[1:0] != 2'b00) req_bad = 1'b1;
            SIZE_BAD: req_bad = 1'b1;
            default:  ;
        endcase
    endfunction

endpackage

// File: rtl/mem_initiator_lane_align.sv
// Combinational lane steering: byte mask and replicated store data out, extracted and extended load data back.
module mem_lane_align
    import mem_initiator_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  mask,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic uns);
        logic signed [31:0] s;
        s = {{24{b[7]}}, b};
        return uns ? {24'b0, b} : s;
    endfunction

    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic uns);
        logic signed [31:0] s;
        s = {{16{h[15]}}, h};
        return uns ? {16'b0, h} : s;
    endfunction

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b     = rdata_raw[{offset, 3'b000} +: 8];
        lane_h     = offset[1] ? rdata_raw[31:16] : rdata_raw[15:0];
        mask       = 4'b0000;
        wdata_lane = wdata;
        rdata_ext  = '0;
        case (size)
            SIZE_B: begin
                mask       = 4'b0001 << offset;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = ext_byte(lane_b, is_unsigned);
            end
            SIZE_H: begin
                mask       = 4'b0011 << offset;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = ext_half(lane_h, is_unsigned);
            end
            SIZE_W: begin
                mask       = 4'b1111;
                rdata_ext  = rdata_raw;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_initiator.sv
// Single-outstanding load/store initiator for the on-chip SRAM port, with timeout and error responses.
module mem_initiator
    import mem_initiator_pkg::*;
#(
    parameter int ADDR_W  = 15,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [31:0]       req_addr_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    output logic [3:0]        mem_byte_select_o,
    input  logic              mem_ready_i,
    input  logic [31:0]       mem_data_i
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e            state;
    logic              read_q, write_q, rsp_valid_q, rsp_err_q;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q, off_q;
    logic              uns_q;
    logic [31:0]       wdata_q, rdata_q;
    logic [3:0]        mask;
    logic [31:0]       wdata_lane, rdata_ext;
    logic              strobe, accept;

    mem_lane_align u_align (
        .size        (size_q),
        .offset      (off_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rdata_raw   (mem_data_i),
        .mask        (mask),
        .wdata_lane  (wdata_lane),
        .rdata_ext   (rdata_ext)
    );

    assign strobe            = read_q | write_q;
    assign accept            = (state == ST_IDLE) && req_valid_i;
    assign req_ready_o       = (state == ST_IDLE) && !rst_i;
    assign mem_read_o        = read_q;
    assign mem_write_o       = write_q;
    assign mem_addr_o        = strobe ? addr_q : '0;
    assign mem_byte_select_o = strobe ? mask : 4'b0000;
    assign mem_data_o        = write_q ? wdata_lane : '0;
    assign rsp_valid_o       = rsp_valid_q;
    assign rsp_err_o         = rsp_err_q;
    assign rsp_rdata_o       = rsp_valid_q ? rdata_q : '0;

    // Request fields and load result; masked at the outputs, so they need no reset.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            addr_q  <= req_addr_i[ADDR_W+1:2];
            size_q  <= req_size_i;
            off_q   <= req_addr_i[1:0];
            uns_q   <= req_unsigned_i;
            wdata_q <= req_wdata_i;
            rdata_q <= '0;
        end else if (state == ST_READ && mem_ready_i) begin
            rdata_q <= rdata_ext;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        cnt <= '0;
                        if (req_bad(req_size_i, req_addr_i, ADDR_W)) begin
                            state       <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else if (req_we_i) begin
                            state   <= ST_WRITE;
                            write_q <= 1'b1;
                        end else begin
                            state  <= ST_READ;
                            read_q <= 1'b1;
                        end
                    end
                end
                ST_READ, ST_WRITE: begin
                    // Ready in the final counted cycle still completes normally.
                    if (mem_ready_i || cnt == CNT_W'(TIMEOUT - 1)) begin
                        state       <= ST_RESP;
                        read_q      <= 1'b0;
                        write_q     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= !mem_ready_i;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator: SRAM wrapper model plus scoreboard of expected responses per request.
module tb_mem_initiator;

    localparam int ADDR_W  = 15;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_we, req_uns;
    logic [31:0]       req_addr, req_wdata;
    logic [1:0]        req_size;
    logic              rsp_valid, rsp_err;
    logic [31:0]       rsp_rdata;
    logic              mem_read, mem_write, mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;
    logic [3:0]        mem_sel;

    always #5 clk = ~clk;

    mem_initiator #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_size_i(req_size), .req_unsigned_i(req_uns),
        .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
        .mem_data_o(mem_wdata), .mem_byte_select_o(mem_sel),
        .mem_ready_i(mem_ready), .mem_data_i(mem_rdata)
    );

    // SRAM wrapper model: writes complete at once, reads need one cycle after a rise or address change.
    logic [31:0]       sram [0:255];
    logic              rd_prev;
    logic [ADDR_W-1:0] addr_prev;
    logic              stall;

    assign mem_ready = !stall && (mem_write || (mem_read && rd_prev && mem_addr == addr_prev));
    assign mem_rdata = mem_read ? sram[mem_addr[7:0]] : 32'h0;

    always @(posedge clk) begin
        rd_prev   <= mem_read;
        addr_prev <= mem_addr;
        if (mem_write && mem_ready)
            for (int b = 0; b < 4; b++)
                if (mem_sel[b]) sram[mem_addr[7:0]][b*8 +: 8] = mem_wdata[b*8 +: 8];
    end

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nstrobe;
        logic [3:0]  sel;
        logic [31:0] mdata;
    } vec_t;

    vec_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic              acc_ok, got, o_err;
    logic [31:0]       o_rdata, s_data;
    logic [3:0]        s_sel;
    logic [ADDR_W-1:0] s_addr;
    int                lat, n_strobe;

    function automatic vec_t mk(string name, logic we, logic [31:0] addr, logic [1:0] size,
                                logic uns, logic [31:0] wdata, logic [31:0] rdata, logic err,
                                int lat, int nstrobe, logic [3:0] sel, logic [31:0] mdata);
        vec_t v;
        v.name = name; v.we = we; v.addr = addr; v.size = size; v.uns = uns; v.wdata = wdata;
        v.rdata = rdata; v.err = err; v.lat = lat; v.nstrobe = nstrobe; v.sel = sel; v.mdata = mdata;
        return v;
    endfunction

    // Drive one request and collect what the DUT does until its response (bounded).
    task automatic issue(input vec_t v);
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_size = v.size;
        req_uns = v.uns; req_wdata = v.wdata;
        acc_ok = req_ready;
        @(posedge clk); #1;
        req_valid = 1'b0;
        got = 1'b0; lat = 0; n_strobe = 0; s_addr = '0; s_sel = '0; s_data = '0;
        o_rdata = '0; o_err = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (mem_read || mem_write) begin
                if (n_strobe == 0) begin s_addr = mem_addr; s_sel = mem_sel; s_data = mem_wdata; end
                n_strobe++;
            end
            if (rsp_valid) begin got = 1'b1; lat = k; o_rdata = rsp_rdata; o_err = rsp_err; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_size = 2'b10;
        req_uns = 1'b0; req_wdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if ({req_ready, mem_read, mem_write, rsp_valid, mem_sel} !== 8'h00) begin
                n_err++;
                $display("FAIL reset_cyc%0d ready/rd/wr/rsp/sel got %b%b%b%b_%b want 0000_0000",
                         i, req_ready, mem_read, mem_write, rsp_valid, mem_sel);
            end
        end
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_release ready got %b want 1", req_ready);
        end
    endtask

    task automatic test_store_load();
        vec_t t[$];
        vec_t e;
        t.push_back(mk("st_w_10",  1, 32'h10, 2'b10, 0, 32'hDEADBEEF, 32'h0,        0, 2, 1, 4'b1111, 32'hDEADBEEF));
        t.push_back(mk("st_b_13",  1, 32'h13, 2'b00, 0, 32'h000000A5, 32'h0,        0, 2, 1, 4'b1000, 32'hA5A5A5A5));
        t.push_back(mk("ld_bs_13", 0, 32'h13, 2'b00, 0, 32'h0,        32'hFFFFFFA5, 0, 3, 2, 4'b1000, 32'h0));
        t.push_back(mk("ld_bu_13", 0, 32'h13, 2'b00, 1, 32'h0,        32'h000000A5, 0, 3, 2, 4'b1000, 32'h0));
        t.push_back(mk("ld_hs_12", 0, 32'h12, 2'b01, 0, 32'h0,        32'hFFFFA5AD, 0, 3, 2, 4'b1100, 32'h0));
        t.push_back(mk("ld_w_10",  0, 32'h10, 2'b10, 0, 32'h0,        32'hA5ADBEEF, 0, 3, 2, 4'b1111, 32'h0));
        t.push_back(mk("st_h_22",  1, 32'h22, 2'b01, 0, 32'h00001234, 32'h0,        0, 2, 1, 4'b1100, 32'h12341234));
        t.push_back(mk("ld_hu_22", 0, 32'h22, 2'b01, 1, 32'h0,        32'h00001234, 0, 3, 2, 4'b1100, 32'h0));
        t.push_back(mk("ld_bu_23", 0, 32'h23, 2'b00, 1, 32'h0,        32'h00000012, 0, 3, 2, 4'b1000, 32'h0));
        t.push_back(mk("ld_bs_11", 0, 32'h11, 2'b00, 0, 32'h0,        32'hFFFFFFBE, 0, 3, 2, 4'b0010, 32'h0));
        t.push_back(mk("ld_hs_10", 0, 32'h10, 2'b01, 0, 32'h0,        32'hFFFFBEEF, 0, 3, 2, 4'b0011, 32'h0));
        foreach (t[i]) begin
            sb.push_back(t[i]);
            issue(t[i]);
            e = sb.pop_front();
            n_vec++;
            if (!acc_ok) begin n_err++; $display("FAIL %s accept ready got 0 want 1", e.name); end
            n_vec++;
            if (!got) begin
                n_err++; $display("FAIL %s no response within 200 cycles", e.name);
            end else begin
                n_vec++;
                if (o_rdata !== e.rdata) begin n_err++; $display("FAIL %s rdata got %h want %h", e.name, o_rdata, e.rdata); end
                n_vec++;
                if (o_err !== e.err) begin n_err++; $display("FAIL %s err got %b want %b", e.name, o_err, e.err); end
                n_vec++;
                if (lat != e.lat) begin n_err++; $display("FAIL %s latency got %0d want %0d", e.name, lat, e.lat); end
                n_vec++;
                if (n_strobe != e.nstrobe) begin n_err++; $display("FAIL %s strobe cycles got %0d want %0d", e.name, n_strobe, e.nstrobe); end
                n_vec++;
                if (s_addr !== e.addr[ADDR_W+1:2] || s_sel !== e.sel || s_data !== e.mdata) begin
                    n_err++;
                    $display("FAIL %s addr/sel/data got %h/%b/%h want %h/%b/%h", e.name,
                             s_addr, s_sel, s_data, e.addr[ADDR_W+1:2], e.sel, e.mdata);
                end
            end
        end
    endtask

    task automatic test_errors();
        vec_t t[$];
        vec_t e;
        t.push_back(mk("ld_h_mis",  0, 32'h21,       2'b01, 0, 32'h0,  32'h0, 1, 1, 0, 4'b0, 32'h0));
        t.push_back(mk("ld_size11", 0, 32'h10,       2'b11, 0, 32'h0,  32'h0, 1, 1, 0, 4'b0, 32'h0));
        t.push_back(mk("st_w_mis",  1, 32'h12,       2'b10, 0, 32'h77, 32'h0, 1, 1, 0, 4'b0, 32'h0));
        t.push_back(mk("ld_b_oor",  0, 32'h0002_0000, 2'b00, 0, 32'h0, 32'h0, 1, 1, 0, 4'b0, 32'h0));
        t.push_back(mk("st_b_top",  1, 32'hFFFF_FFFF, 2'b00, 0, 32'h9, 32'h0, 1, 1, 0, 4'b0, 32'h0));
        t.push_back(mk("ld_b_last", 0, 32'h0001_FFFF, 2'b00, 1, 32'h0, 32'h0, 0, 3, 2, 4'b0, 32'h0));
        foreach (t[i]) begin
            sb.push_back(t[i]);
            issue(t[i]);
            e = sb.pop_front();
            n_vec++;
            if (!got) begin
                n_err++; $display("FAIL %s no response within 200 cycles", e.name);
            end else begin
                n_vec++;
                if ({o_err, o_rdata} !== {e.err, e.rdata}) begin
                    n_err++; $display("FAIL %s err/rdata got %b/%h want %b/%h", e.name, o_err, o_rdata, e.err, e.rdata);
                end
                n_vec++;
                if (lat != e.lat || n_strobe != e.nstrobe) begin
                    n_err++; $display("FAIL %s latency/strobes got %0d/%0d want %0d/%0d", e.name, lat, n_strobe, e.lat, e.nstrobe);
                end
            end
        end
    endtask

    task automatic test_timeout();
        vec_t e;
        stall = 1'b1;
        sb.push_back(mk("ld_timeout", 0, 32'h10, 2'b10, 0, 32'h0, 32'h0, 1, TIMEOUT + 1, TIMEOUT, 4'b1111, 32'h0));
        issue(sb[0]);
        e = sb.pop_front();
        n_vec++;
        if (!got || o_err !== 1'b1 || o_rdata !== 32'h0) begin
            n_err++; $display("FAIL %s got=%b err=%b rdata=%h want got=1 err=1 rdata=0", e.name, got, o_err, o_rdata);
        end
        n_vec++;
        if (lat != e.lat || n_strobe != e.nstrobe) begin
            n_err++; $display("FAIL %s latency/strobes got %0d/%0d want %0d/%0d", e.name, lat, n_strobe, e.lat, e.nstrobe);
        end
        stall = 1'b0;
        sb.push_back(mk("ld_after_to", 0, 32'h10, 2'b10, 0, 32'h0, 32'hA5ADBEEF, 0, 3, 2, 4'b1111, 32'h0));
        issue(sb[0]);
        e = sb.pop_front();
        n_vec++;
        if (!got || o_err !== 1'b0 || o_rdata !== e.rdata || lat != e.lat) begin
            n_err++; $display("FAIL %s got=%b err=%b rdata=%h lat=%0d want 1/0/%h/%0d", e.name, got, o_err, o_rdata, lat, e.rdata, e.lat);
        end
    endtask

    task automatic test_reset_mid();
        vec_t e;
        stall = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_uns = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (mem_read !== 1'b1) begin n_err++; $display("FAIL rstmid_read_active got %b want 1", mem_read); end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({mem_read, mem_write, req_ready, rsp_valid, mem_sel} !== 8'h00) begin
            n_err++; $display("FAIL rstmid_outputs rd/wr/ready/rsp/sel got %b%b%b%b_%b want 0000_0000",
                              mem_read, mem_write, req_ready, rsp_valid, mem_sel);
        end
        rst = 1'b0; stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if ({rsp_valid, mem_read, mem_write} !== 3'b000) begin
                n_err++; $display("FAIL rstmid_quiet_cyc%0d rsp/rd/wr got %b%b%b want 000", i, rsp_valid, mem_read, mem_write);
            end
        end
        sb.push_back(mk("ld_after_rst", 0, 32'h13, 2'b00, 1, 32'h0, 32'h000000A5, 0, 3, 2, 4'b1000, 32'h0));
        issue(sb[0]);
        e = sb.pop_front();
        n_vec++;
        if (!got || o_err !== 1'b0 || o_rdata !== e.rdata || lat != e.lat) begin
            n_err++; $display("FAIL %s got=%b err=%b rdata=%h lat=%0d want 1/0/%h/%0d", e.name, got, o_err, o_rdata, lat, e.rdata, e.lat);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) sram[i] = 32'h0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0; req_uns = 1'b0; req_wdata = '0;
        test_reset();
        test_store_load();
        test_errors();
        test_timeout();
        test_reset_mid();
        n_vec++;
        if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
